riscv_lsu: RTL and testbench
============================

# riscv_lsu

Load/store unit between the `riscv_cpu` core and its single-port synchronous RAM (`ramm`: word-addressed, one `wren`, no byte enables, registered address, `q` valid the cycle after the address edge). It accepts one byte-addressed load or store from the core at a time. It performs RAM read-modify-write for sub-word stores, and extracts and extends sub-word load data. It also decodes one memory-mapped LED register driving the board LEDs.

## Interface
Parameters:
- `AW`, 10, RAM word-address width; RAM spans byte addresses 0 .. 4·2^AW−1.
- `LED_ADDR`, 32'h8000_0000, byte address of the LED register; word-aligned.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `req_valid`  in  1  core request present.
- `req_ready`  out  1  high exactly when state is IDLE.
- `req_we`  in  1  1 = store, 0 = load.
- `req_size`  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
- `req_unsigned`  in  1  loads only: 1 = zero-extend (LBU/LHU), 0 = sign-extend.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-aligned (bits [7:0] for byte, [15:0] for half).
- `rsp_valid`  out  1  one-cycle pulse; completes the accepted request.
- `rsp_rdata`  out  32  load result; 0 for stores and errors.
- `rsp_err`  out  1  misaligned, illegal-size, or unmapped access.
- `mem_addr`  out  AW  RAM word address.
- `mem_wdata`  out  32  RAM write data.
- `mem_wren`  out  1  RAM write enable.
- `mem_q`  in  32  RAM read data.
- `leds`  out  4  LED register.

## Operation
- **Handshake:** a request is accepted at an edge where `req_valid && req_ready`. At most one request is outstanding. Each accepted request produces exactly one `rsp_valid` pulse.
- **Classification at accept, in priority order:**
  - ERR: size 3; half with `addr[0]`; word with `addr[1:0]≠0`; or address neither in RAM range nor in LED_ADDR's word.
  - LED: `addr[31:2]==LED_ADDR[31:2]`.
  - RAM: in RAM range.
- **States:**
  - IDLE: accepts requests.
  - MERGE: sub-word RAM store, waiting for read data.
  - LOADW: RAM load, waiting for `mem_q`.
- **IDLE (combinational RAM drive):**
  - `mem_addr = req_addr[AW+1:2]`.
  - `mem_wdata = req_wdata`.
  - `mem_wren = req_valid && req_we && size==2 && class RAM`.
- **RAM word store:** written at the accept edge; stay in IDLE; register a response.
- **RAM sub-word store:** accept edge performs a read; go to MERGE.
  - In MERGE: `mem_addr` = latched word address. `mem_wdata` = `mem_q` with the addressed lane replaced (little-endian; byte lane `addr[1:0]`, half lane `addr[1]`). `mem_wren = 1`.
  - Next edge writes the merged word, responds, and returns to IDLE.
- **RAM load:** accept edge reads; go to LOADW.
  - In LOADW: select the lane from `mem_q`, extend to 32 bits per `req_unsigned`.
  - Next edge registers `rsp_rdata`, responds, and returns to IDLE.
- **LED:**
  - Store: `leds <= req_wdata[3:0]` at the accept edge, for any legal aligned size.
  - Load: returns `{28'b0, leds}`.
  - Neither touches the RAM (`mem_wren=0`). Respond next edge; stay in IDLE.
- **ERR:** no RAM or LED side effect. Respond next edge with `rsp_err=1`, `rsp_rdata=0`; stay in IDLE.
- `mem_wren` is 0 in LOADW and in IDLE whenever no word-store RAM request is being accepted.

## Timing
- **Reset values:** state IDLE, `rsp_valid=0`, `rsp_err=0`, `rsp_rdata=0`, `leds=0`.
  - `mem_wren` is forced 0 at once while `reset` is high.
  - Reset during MERGE aborts the write (RAM word unchanged) and produces no response.
- **Latency:** `rsp_valid` is high in the cycle after the completing edge. Accept at edge E0:
  - Word store, LED, ERR: response visible after E0 (1 cycle). Throughput 1 request/cycle.
  - Sub-word store, load: response visible after E1 (2 cycles). `req_ready=0` between E0 and E1.
- `rsp_valid` may be high in the same cycle a new request is accepted; the core must not depend on a gap.
- `rsp_rdata`/`rsp_err` are valid only while `rsp_valid=1`. They hold their values otherwise.
- Address wrap: none. Addresses ≥ 4·2^AW other than the LED word are ERR, never aliased.

## Test plan
- **Byte store merge:** RAM[0]=32'h11223344; store byte 8'hAB to addr 2 → one read, then write 32'h11AB3344 on the next edge; `rsp_valid` 2 cycles after accept, `rsp_err=0`.
- **Load extension:** RAM[1]=32'h0000_80F0; LH addr 4 → 32'hFFFF80F0; LHU → 32'h000080F0; LB addr 5 → 32'hFFFFFF80; LW → 32'h000080F0.
- **Back-to-back word stores:** four SWs with `req_valid` held high → `req_ready` stays 1, one write per cycle, four `rsp_valid` pulses.
- **LED register:** SW 32'h5 to 32'h8000_0000 → `leds=4'b0101` after the accept edge, no `mem_wren`; LW there → `rsp_rdata=32'h5`.
- **Errors:** LW addr 2, LH addr 1, size 3, LW addr 32'h4000_0000 → each gives a 1-cycle-latency `rsp_err=1`, `rsp_rdata=0`, no RAM write, `leds` unchanged.
- **Reset mid-op:** assert `reset` during MERGE of an SB → `mem_wren` drops at once, RAM word unchanged, no `rsp_valid`, `req_ready=1` after release.

Source files
------------

// File: rtl/riscv_lsu.sv
// riscv_lsu: load/store unit between the core and a word-addressed single-port
// synchronous RAM. Handles sub-word store read-modify-write, load lane
// extraction/extension, and one memory-mapped LED register.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | ready for a request; word stores / LED / errors finish here
// S_MERGE | sub-word store: RAM word arriving, merged word written now
// S_LOADW | RAM load: RAM word arriving, lane extracted and registered
module riscv_lsu #(
    parameter int          AW       = 10,
    parameter logic [31:0] LED_ADDR = 32'h8000_0000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [1:0]    req_size,
    input  logic          req_unsigned,
    input  logic [31:0]   req_addr,
    input  logic [31:0]   req_wdata,
    output logic          rsp_valid,
    output logic [31:0]   rsp_rdata,
    output logic          rsp_err,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic          mem_wren,
    input  logic [31:0]   mem_q,
    output logic [3:0]    leds
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MERGE = 2'd1,
        S_LOADW = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic          rsp_err_q, rsp_err_d;
    logic [31:0]   rsp_rdata_q, rsp_rdata_d;
    logic [3:0]    leds_q, leds_d;

    // request fields held while the RAM word is in flight
    logic [AW-1:0] word_addr_q;
    logic [1:0]    lane_q;
    logic [1:0]    size_q;
    logic          uns_q;
    logic [31:0]   wdata_q;

    logic          accept;
    logic          cls_err, cls_led, cls_ram;
    logic          wren_raw;
    logic [31:0]   merged;
    logic [31:0]   shifted;
    logic [31:0]   load_data;

    assign req_ready = (state_q == S_IDLE);
    assign accept    = req_valid && req_ready;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;
    assign leds      = leds_q;
    // reset must kill an in-flight merge write immediately, not at the next edge
    assign mem_wren  = wren_raw && !reset;

    // classify the presented request: error beats LED beats RAM
    always_comb begin
        logic sz_bad, misaligned, is_led, in_ram;
        sz_bad     = (req_size == 2'd3);
        misaligned = ((req_size == 2'd1) && req_addr[0]) ||
                     ((req_size == 2'd2) && (req_addr[1:0] != 2'b00));
        is_led     = (req_addr[31:2] == LED_ADDR[31:2]);
        in_ram     = (req_addr[31:AW+2] == '0);
        cls_err    = sz_bad || misaligned || (!is_led && !in_ram);
        cls_led    = !cls_err && is_led;
        cls_ram    = !cls_err && !is_led && in_ram;
    end

    // replace the addressed little-endian lane of the fetched word
    always_comb begin
        merged = mem_q;
        if (size_q == 2'd0) begin
            merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
        end else begin
            merged[{lane_q[1], 4'b0000} +: 16] = wdata_q[15:0];
        end
    end

    // pick the load lane and extend it to 32 bits
    always_comb begin
        shifted = mem_q >> {lane_q, 3'b000};
        case (size_q)
            2'd0:    load_data = uns_q ? {24'h0, shifted[7:0]}
                                       : {{24{shifted[7]}}, shifted[7:0]};
            2'd1:    load_data = uns_q ? {16'h0, shifted[15:0]}
                                       : {{16{shifted[15]}}, shifted[15:0]};
            default: load_data = mem_q;
        endcase
    end

    // next state, RAM drive and response generation
    always_comb begin
        state_d     = state_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;
        leds_d      = leds_q;
        mem_addr    = req_addr[AW+1:2];
        mem_wdata   = req_wdata;
        wren_raw    = 1'b0;
        case (state_q)
            S_IDLE: begin
                wren_raw = req_valid && req_we && (req_size == 2'd2) && cls_ram;
                if (accept) begin
                    if (cls_err) begin
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = 32'h0;
                    end else if (cls_led) begin
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b0;
                        if (req_we) begin
                            leds_d      = req_wdata[3:0];
                            rsp_rdata_d = 32'h0;
                        end else begin
                            rsp_rdata_d = {28'h0, leds_q};
                        end
                    end else if (req_we && (req_size == 2'd2)) begin
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b0;
                        rsp_rdata_d = 32'h0;
                    end else if (req_we) begin
                        state_d = S_MERGE;
                    end else begin
                        state_d = S_LOADW;
                    end
                end
            end
            S_MERGE: begin
                mem_addr    = word_addr_q;
                mem_wdata   = merged;
                wren_raw    = 1'b1;
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b0;
                rsp_rdata_d = 32'h0;
                state_d     = S_IDLE;
            end
            S_LOADW: begin
                mem_addr    = word_addr_q;
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b0;
                rsp_rdata_d = load_data;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // state, response and LED registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'h0;
            leds_q      <= 4'h0;
        end else begin
            state_q     <= state_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            leds_q      <= leds_d;
        end
    end

    // capture the request at accept for the second cycle of two-cycle ops
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_addr_q <= '0;
            lane_q      <= 2'b00;
            size_q      <= 2'b00;
            uns_q       <= 1'b0;
            wdata_q     <= 32'h0;
        end else if (accept) begin
            word_addr_q <= req_addr[AW+1:2];
            lane_q      <= req_addr[1:0];
            size_q      <= req_size;
            uns_q       <= req_unsigned;
            wdata_q     <= req_wdata;
        end
    end

endmodule

// File: tb/tb_riscv_lsu.sv
// Directed bench for riscv_lsu with a behavioural synchronous RAM and a
// response scoreboard (expected error/data/arrival cycle per request).
module tb_riscv_lsu;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [1:0]    req_size;
    logic          req_unsigned;
    logic [31:0]   req_addr;
    logic [31:0]   req_wdata;
    logic          rsp_valid;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          mem_wren;
    logic [31:0]   mem_q;
    logic [3:0]    leds;

    always #5 clk = ~clk;

    riscv_lsu #(.AW(AW), .LED_ADDR(32'h8000_0000)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_wren     (mem_wren),
        .mem_q        (mem_q),
        .leds         (leds)
    );

    // RAM model: registered address, q follows the next cycle; preload port for setup
    logic [31:0]   ram [0:(1<<AW)-1];
    logic [AW-1:0] ram_addr_q;
    logic          pre_we;
    logic [AW-1:0] pre_addr;
    logic [31:0]   pre_data;

    always @(posedge clk) begin
        if (pre_we) ram[pre_addr] <= pre_data;
        else if (mem_wren) ram[mem_addr] <= mem_wdata;
        ram_addr_q <= mem_addr;
    end
    assign mem_q = ram[ram_addr_q];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          at;
    } exp_t;
    exp_t sb[$];

    int total = 0;
    int bad   = 0;
    int nwr   = 0;
    int n0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // one cycle: count a pending RAM write, cross the edge, score any response
    task automatic step();
        exp_t e;
        #1;
        if (mem_wren === 1'b1) nwr++;
        @(negedge clk);
        if (rsp_valid === 1'b1) begin
            chk("rsp_expected", {31'h0, sb.size() != 0}, 32'h1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("rsp_err", {31'h0, rsp_err}, {31'h0, e.err});
                chk("rsp_rdata", rsp_rdata, e.rdata);
                chk("rsp_cycle", cyc, e.at);
            end
        end
    endtask

    task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic exp_err, input logic [31:0] exp_rdata,
                         input int lat, input logic push);
        exp_t e;
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        chk("ready_at_issue", {31'h0, req_ready}, 32'h1);
        if (push) begin
            e.err   = exp_err;
            e.rdata = exp_rdata;
            e.at    = cyc + lat;
            sb.push_back(e);
        end
        step();
        req_valid = 1'b0;
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 8 && req_ready !== 1'b1; i++) step();
        chk("ready_wait", {31'h0, req_ready}, 32'h1);
    endtask

    task automatic poke(input int a, input logic [31:0] d);
        pre_we   = 1'b1;
        pre_addr = AW'(a);
        pre_data = d;
        @(negedge clk);
        pre_we   = 1'b0;
    endtask

    function automatic logic [31:0] ext_b(input logic [31:0] w, input int lane, input logic uns);
        logic [7:0] b;
        b = w[8*lane +: 8];
        return uns ? {24'h0, b} : {{24{b[7]}}, b};
    endfunction

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] exp;
    } ld_t;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } er_t;

    initial begin
        ld_t ld_tab[$];
        er_t er_tab[$];

        reset = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0;
        pre_we = 1'b0; pre_addr = '0; pre_data = 32'h0;
        @(negedge clk);
        poke(0,    32'h1122_3344);
        poke(1,    32'h0000_80F0);
        poke(2,    32'h7F80_01FE);
        poke(3,    32'hCAFE_F00D);
        poke(4,    32'hDEAD_BEEF);
        poke(1023, 32'hA5A5_A5A5);

        // reset values, and wren forced low even for a word store request
        chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        chk("rst_rsp_err", {31'h0, rsp_err}, 32'h0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_leds", {28'h0, leds}, 32'h0);
        chk("rst_ready", {31'h0, req_ready}, 32'h1);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_addr = 32'h0;
        #1;
        chk("rst_wren_forced", {31'h0, mem_wren}, 32'h0);
        req_valid = 1'b0; req_we = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        step();

        // byte store merge
        n0 = nwr;
        issue(1'b1, 2'd0, 1'b0, 32'h2, 32'h0000_00AB, 1'b0, 32'h0, 2, 1'b1);
        chk("merge_ready_low", {31'h0, req_ready}, 32'h0);
        wait_ready();
        chk("merge_ram0", ram[0], 32'h11AB_3344);
        chk("merge_writes", nwr - n0, 32'd1);

        // loads with extension, including the last RAM word
        ld_tab.push_back('{32'h4, 2'd1, 1'b0, 32'hFFFF_80F0});
        ld_tab.push_back('{32'h4, 2'd1, 1'b1, 32'h0000_80F0});
        ld_tab.push_back('{32'h5, 2'd0, 1'b0, 32'hFFFF_FF80});
        ld_tab.push_back('{32'h4, 2'd2, 1'b0, 32'h0000_80F0});
        ld_tab.push_back('{32'h8, 2'd1, 1'b0, 32'h0000_01FE});
        ld_tab.push_back('{32'hA, 2'd1, 1'b1, 32'h0000_7F80});
        ld_tab.push_back('{32'hFFC, 2'd2, 1'b0, 32'hA5A5_A5A5});
        for (int i = 0; i < 4; i++) begin
            ld_tab.push_back('{32'h8 + i, 2'd0, 1'b0, ext_b(32'h7F80_01FE, i, 1'b0)});
            ld_tab.push_back('{32'h8 + i, 2'd0, 1'b1, ext_b(32'h7F80_01FE, i, 1'b1)});
        end
        n0 = nwr;
        foreach (ld_tab[i]) begin
            issue(1'b0, ld_tab[i].size, ld_tab[i].uns, ld_tab[i].addr, 32'hFFFF_FFFF,
                  1'b0, ld_tab[i].exp, 2, 1'b1);
            wait_ready();
        end
        chk("load_no_writes", nwr - n0, 32'd0);

        // half then byte merge into one word
        issue(1'b1, 2'd1, 1'b0, 32'h12, 32'hFFFF_1234, 1'b0, 32'h0, 2, 1'b1);
        wait_ready();
        chk("merge_half", ram[4], 32'h1234_BEEF);
        issue(1'b1, 2'd0, 1'b0, 32'h11, 32'hFFFF_FF00, 1'b0, 32'h0, 2, 1'b1);
        wait_ready();
        chk("merge_byte1", ram[4], 32'h1234_00EF);

        // back-to-back word stores
        n0 = nwr;
        for (int i = 0; i < 4; i++)
            issue(1'b1, 2'd2, 1'b0, 32'h20 + 4 * i, 32'h1000_0000 + i, 1'b0, 32'h0, 1, 1'b1);
        chk("b2b_writes", nwr - n0, 32'd4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("b2b_ram%0d", i), ram[8 + i], 32'h1000_0000 + i);

        // LED register
        n0 = nwr;
        issue(1'b1, 2'd2, 1'b0, 32'h8000_0000, 32'h0000_0005, 1'b0, 32'h0, 1, 1'b1);
        chk("led_store", {28'h0, leds}, 32'h5);
        issue(1'b0, 2'd2, 1'b0, 32'h8000_0000, 32'h0, 1'b0, 32'h5, 1, 1'b1);
        issue(1'b1, 2'd0, 1'b0, 32'h8000_0003, 32'h0000_00FA, 1'b0, 32'h0, 1, 1'b1);
        chk("led_byte_store", {28'h0, leds}, 32'hA);
        issue(1'b0, 2'd0, 1'b0, 32'h8000_0001, 32'h0, 1'b0, 32'hA, 1, 1'b1);
        chk("led_no_writes", nwr - n0, 32'd0);

        // errors: no side effects, 1-cycle latency
        er_tab.push_back('{1'b0, 2'd2, 32'h2,         32'h0});
        er_tab.push_back('{1'b0, 2'd1, 32'h1,         32'h0});
        er_tab.push_back('{1'b0, 2'd3, 32'h0,         32'h0});
        er_tab.push_back('{1'b0, 2'd2, 32'h4000_0000, 32'h0});
        er_tab.push_back('{1'b1, 2'd2, 32'h1000,      32'h0BAD_0BAD});
        er_tab.push_back('{1'b1, 2'd1, 32'h8000_0001, 32'h0000_000F});
        er_tab.push_back('{1'b1, 2'd2, 32'h8000_0004, 32'h0000_0003});
        er_tab.push_back('{1'b1, 2'd3, 32'h8000_0000, 32'h0000_0001});
        n0 = nwr;
        foreach (er_tab[i])
            issue(er_tab[i].we, er_tab[i].size, 1'b0, er_tab[i].addr, er_tab[i].wdata,
                  1'b1, 32'h0, 1, 1'b1);
        chk("err_no_writes", nwr - n0, 32'd0);
        chk("err_leds_kept", {28'h0, leds}, 32'hA);
        chk("err_ram0_kept", ram[0], 32'h11AB_3344);

        // reset in the middle of a merge
        issue(1'b1, 2'd0, 1'b0, 32'hC, 32'h0000_0055, 1'b0, 32'h0, 2, 1'b0);
        chk("merge_wren_high", {31'h0, mem_wren}, 32'h1);
        #2;
        reset = 1'b1;
        #1;
        chk("rst_mid_wren", {31'h0, mem_wren}, 32'h0);
        chk("rst_mid_ready", {31'h0, req_ready}, 32'h1);
        step();
        reset = 1'b0;
        step();
        step();
        chk("rst_mid_ram3", ram[3], 32'hCAFE_F00D);
        chk("rst_mid_leds", {28'h0, leds}, 32'h0);
        issue(1'b0, 2'd2, 1'b0, 32'hC, 32'h0, 1'b0, 32'hCAFE_F00D, 2, 1'b1);
        wait_ready();

        step();
        step();
        chk("sb_empty", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
